// File: rtl/pixel_stream_src.sv
// pixel_stream_src: frame memory plus raster-order valid/ready pixel streamer.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_en, wr_addr, wr_data     image load port (r*WIDTH+c), honoured in IDLE only
//   start, busy, done           frame request, in-progress flag, end-of-frame pulse
//   m_valid, m_ready, m_pixel   stream handshake and pixel value
//   m_x, m_y                    coordinates of m_pixel
//   m_sof, m_eol, m_eof         first of frame, last of line, last of frame
//   m_border                    pixel lies on the outer image border
module pixel_stream_src #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int BITW   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr,
    input  logic [BITW-1:0]                   wr_data,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [BITW-1:0]                   m_pixel,
    output logic [$clog2(WIDTH)-1:0]          m_x,
    output logic [$clog2(HEIGHT)-1:0]         m_y,
    output logic                              m_sof,
    output logic                              m_eol,
    output logic                              m_eof,
    output logic                              m_border
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);

    localparam logic [AW:0]   NPIX_C = (AW+1)'(NPIX);
    localparam logic [XW-1:0] XMAX   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX   = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            done_q, done_d;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [BITW-1:0] rdata_q;
    logic [BITW-1:0] mem_q [NPIX];
    logic            hs;
    logic            last_px;
    logic            wr_ok;

    assign hs      = m_valid & m_ready;
    assign last_px = (x_q == XMAX) && (y_q == YMAX);
    assign wr_ok   = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NPIX_C);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = addr_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                // read data lands this cycle; present it next
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (last_px) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // prefetch next raster pixel so the stream never bubbles
                        rd_en  = 1'b1;
                        addr_d = rd_addr;
                        if (x_q == XMAX) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // synchronous read port; holds its value when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign m_valid  = (state_q == SEND);
    assign m_pixel  = rdata_q;
    assign m_x      = x_q;
    assign m_y      = y_q;
    // flags gated by valid so they read zero while idle or in reset
    assign m_sof    = m_valid && (x_q == '0) && (y_q == '0);
    assign m_eol    = m_valid && (x_q == XMAX);
    assign m_eof    = m_valid && last_px;
    assign m_border = m_valid &&
                      ((x_q == '0) || (x_q == XMAX) ||
                       (y_q == '0) || (y_q == YMAX));

endmodule

// File: tb/tb_pixel_stream_src.sv
// tb_pixel_stream_src: scoreboard bench for pixel_stream_src.
// Expected pixels are queued per frame; a negedge monitor pops on handshake.
module tb_pixel_stream_src;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int BW = 8;
    localparam int N  = W * H;

    typedef struct {
        int pix;
        int x;
        int y;
        bit sof;
        bit eol;
        bit eof;
        bit brd;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [9:0]    wr_addr;
    logic [BW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_pixel;
    logic [4:0]    m_x;
    logic [4:0]    m_y;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          m_border;

    pixel_stream_src #(
        .WIDTH (W),
        .HEIGHT(H),
        .BITW  (BW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_pixel (m_pixel),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_eof   (m_eof),
        .m_border(m_border)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   img [N];
    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_cnt, sof_cnt, eol_cnt, eof_cnt, brd_cnt;
    int   done_cnt, done_cyc, first_v_cyc, s_cyc;
    bit   seen_v;
    bit   rnd_ready = 1'b0;
    bit   prev_stall = 1'b0;
    logic [BW-1:0] p_pix;
    logic [4:0]    p_x, p_y;
    logic [3:0]    p_flg;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    // downstream ready: always 1 or pseudo-random
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_pixel", m_pixel, p_pix);
                chk("stall_x", m_x, p_x);
                chk("stall_y", m_y, p_y);
                chk("stall_flags", {m_sof, m_eol, m_eof, m_border}, p_flg);
            end
            if (m_valid && !seen_v) begin
                seen_v      = 1'b1;
                first_v_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                sof_cnt += int'(m_sof);
                eol_cnt += int'(m_eol);
                eof_cnt += int'(m_eof);
                brd_cnt += int'(m_border);
                if (exp_q.size() == 0) begin
                    fail("extra_pixel");
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", m_pixel, e.pix);
                    chk("x", m_x, e.x);
                    chk("y", m_y, e.y);
                    chk("sof", m_sof, e.sof);
                    chk("eol", m_eol, e.eol);
                    chk("eof", m_eof, e.eof);
                    chk("border", m_border, e.brd);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy", busy, 0);
                chk("done_valid", m_valid, 0);
            end
            prev_stall = m_valid && !m_ready;
            p_pix      = m_pixel;
            p_x        = m_x;
            p_y        = m_y;
            p_flg      = {m_sof, m_eol, m_eof, m_border};
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_x"}, m_x, 0);
        chk({tag, "_y"}, m_y, 0);
        chk({tag, "_pixel"}, m_pixel, 0);
        chk({tag, "_flags"}, {m_sof, m_eol, m_eof, m_border}, 0);
    endtask

    task automatic load_img(input int kind);
        int r, c, v;
        for (int i = 0; i < N; i++) begin
            r = i / W;
            c = i % W;
            if (kind == 0)
                v = (r * W + c) & 255;
            else
                v = (r >= 8 && r <= 23 && c >= 8 && c <= 23) ? 255 : 0;
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 8'(v);
            img[i]  = v;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic begin_frame();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.pix = img[i];
            e.x   = i % W;
            e.y   = i / W;
            e.sof = (i == 0);
            e.eol = (e.x == W - 1);
            e.eof = (i == N - 1);
            e.brd = (e.x == 0) || (e.x == W - 1) || (e.y == 0) || (e.y == H - 1);
            exp_q.push_back(e);
        end
        hs_cnt   = 0;
        sof_cnt  = 0;
        eol_cnt  = 0;
        eof_cnt  = 0;
        brd_cnt  = 0;
        done_cnt = 0;
        seen_v   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_frame(input bit timed);
        int k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            fail("done_timeout");
        end else begin
            repeat (4) @(negedge clk);
            chk("done_pulses", done_cnt, 1);
            chk("handshakes", hs_cnt, N);
            chk("sof_count", sof_cnt, 1);
            chk("eol_count", eol_cnt, H);
            chk("eof_count", eof_cnt, 1);
            chk("border_count", brd_cnt, 2 * W + 2 * H - 4);
            chk("queue_left", exp_q.size(), 0);
            chk("idle_valid", m_valid, 0);
            if (timed) begin
                chk("first_valid_lat", first_v_cyc - s_cyc, 2);
                chk("done_lat", done_cyc - s_cyc, N + 2);
            end
        end
    endtask

    initial begin
        int k;
        rst_n   = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // frame 1: ramp, ready always high, exact timing
        load_img(0);
        rnd_ready = 1'b0;
        begin_frame();
        wait_frame(1'b1);

        // frame 2: random ready, write and start while busy
        rnd_ready = 1'b1;
        begin_frame();
        repeat (2) @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = 10'd5;
        wr_data = 8'hAA;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            repeat (100) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_frame(1'b0);
        repeat (20) @(negedge clk);
        chk("no_extra_frame", m_valid, 0);

        // frame 3: pixel 5 must still be the original value
        begin_frame();
        wait_frame(1'b0);

        // reset mid-frame
        rnd_ready = 1'b0;
        begin_frame();
        k = 0;
        while (hs_cnt < 500 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (hs_cnt < 500) fail("reach_pixel_500");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_no_done", done_cnt, 0);
        chk("reset_idle", m_valid, 0);
        load_img(0);
        begin_frame();
        wait_frame(1'b1);

        // square-center image under random ready
        load_img(1);
        rnd_ready = 1'b1;
        begin_frame();
        wait_frame(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_src.md
PIXEL_STREAM_SRC -- requirements
Module: pixel_stream_src

Interface
REQ-001 Parameter WIDTH, default 32, image width in pixels (>=3).
REQ-002 Parameter HEIGHT, default 32, image height in lines (>=3).
REQ-003 Parameter BITW, default 8, pixel width in bits.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  frame-memory write strobe (image load).
REQ-007 wr_addr  input  clog2(WIDTH*HEIGHT)  raster address, r*WIDTH+c.
REQ-008 wr_data  input  BITW  pixel to store.
REQ-009 start  input  1  one-cycle pulse requesting one frame transmission.
REQ-010 busy  output  1  high from accepted start until last pixel handshake.
REQ-011 done  output  1  one-cycle pulse after last pixel handshake.
REQ-012 m_valid  output  1  stream pixel valid.
REQ-013 m_ready  input  1  downstream (convolution) ready.
REQ-014 m_pixel  output  BITW  pixel value.
REQ-015 m_x, m_y  output  clog2(WIDTH), clog2(HEIGHT)  column and row of m_pixel.
REQ-016 m_sof, m_eol, m_eof  output  1 each  first pixel of frame; last pixel of line; last pixel of frame.
REQ-017 m_border  output  1  pixel on row 0, row HEIGHT-1, column 0 or column WIDTH-1.

Function
REQ-018 Frame memory SHALL be WIDTH*HEIGHT x BITW, one write port, one synchronous read port (data one cycle after read enable; holds when not enabled).
REQ-019 Writes SHALL be accepted only in IDLE; wr_en while busy SHALL be ignored; wr_addr >= WIDTH*HEIGHT SHALL be ignored.
REQ-020 FSM states: IDLE, FETCH, SEND.
REQ-021 IDLE: start=1 -> FETCH; read issued for address 0; raster counters cleared; busy=1 next cycle.
REQ-022 FETCH: lasts exactly one cycle -> SEND with m_valid=1 holding pixel (0,0).
REQ-023 SEND: m_pixel and all sideband SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 Handshake = m_valid & m_ready; on handshake of a non-final pixel the next raster address SHALL be read in the same cycle, so m_valid stays 1 and next pixel appears next cycle (1 pixel/clock at m_ready=1).
REQ-025 Raster order: x increments 0..WIDTH-1, wraps to 0 with y+1; after (WIDTH-1,HEIGHT-1) no further read.
REQ-026 Handshake of final pixel -> IDLE; m_valid=0 and busy=0 next cycle; done=1 for exactly that one cycle.
REQ-027 start while busy or in the done cycle's preceding handshake SHALL be ignored; start in IDLE same cycle as done SHALL be accepted.
REQ-028 Sideband flags SHALL be combinationally exact for the presented (m_x,m_y); m_sof only at (0,0), m_eof only at (WIDTH-1,HEIGHT-1), m_eol at x=WIDTH-1.
REQ-029 First m_valid SHALL occur 2 cycles after the start cycle; full-frame time at m_ready=1 = WIDTH*HEIGHT+2 cycles from start to done.
REQ-030 Memory contents SHALL persist across frames; re-start retransmits identical data.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, m_valid=0, m_x=0, m_y=0, m_sof=m_eol=m_eof=m_border=0, m_pixel=0.
REQ-032 Reset mid-frame SHALL abort transmission with no done pulse; memory contents need not be preserved.
REQ-033 After rst_n rises, first rising edge SHALL accept start or wr_en.

Verification
REQ-034 Load 32x32 image pixel=(r*32+c)&0xFF, start, m_ready=1 -> 1024 pixels in raster order, m_pixel matches, first valid 2 cycles after start, done at cycle 1026.
REQ-035 Same load, m_ready toggled pseudo-randomly -> exactly 1024 handshakes, no drop/duplicate, pixel/x/y stable during stalls.
REQ-036 Check flags: m_sof only on pixel 0, m_eol on x=31 (32 times), m_eof once on pixel 1023, m_border on exactly 124 pixels.
REQ-037 wr_en at address 5 with 0xAA during busy -> second frame still shows original pixel 5 value 0x05; start pulses during busy -> no extra frame.
REQ-038 Assert rst_n=0 at pixel 500 -> outputs zero asynchronously, no done; after release and start, full 1024-pixel frame from (0,0).
REQ-039 Load square-center image (0xFF in rows/cols 8..23, else 0x00) -> streamed values match loaded memory exactly.
